stl_stream_sort: RTL and testbench

Streaming insertion sorter, the sequential successor to the parallel sort network. It accepts one key/payload pair per cycle over a valid/ready handshake. Each pair is inserted into a DN-entry sorted register array. When a batch closes, the array is drained in sorted order, one entry per cycle, over a second valid/ready port. It sits between producers of unordered scored items and consumers that need ranked, serialized output with backpressure.

---
 rtl/stl_stream_sort_if.sv | 31 +++
 rtl/stl_stream_sort.sv | 184 ++++++++++++++++++
 tb/tb_stl_stream_sort.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stl_stream_sort_if.sv
// Handshake bundle for the streaming sorter: unordered beats in, ranked entries out.
// The producer/consumer side uses master, the sorter uses slave.
interface stl_stream_sort_if #(
  parameter int DN = 16,
  parameter int CW = 8,
  parameter int DW = 16
);
  localparam int IW = $clog2(DN);

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_key;
  logic [DW-1:0] in_dat;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_key;
  logic [DW-1:0] out_dat;
  logic [IW-1:0] out_idx;
  logic          out_last;

  modport master (
    output in_valid, in_key, in_dat, in_last, out_ready,
    input  in_ready, out_valid, out_key, out_dat, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_key, in_dat, in_last, out_ready,
    output in_ready, out_valid, out_key, out_dat, out_idx, out_last
  );
endinterface

// File: rtl/stl_stream_sort.sv
// Streaming insertion sorter: each accepted beat is placed into a sorted register
// array in one cycle; a closed batch is drained in rank order with backpressure.
module stl_stream_sort #(
  parameter int DN   = 16,
  parameter int CW   = 8,
  parameter int DW   = 16,
  parameter bit MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  stl_stream_sort_if.slave bus
);
  localparam int CNTW = $clog2(DN + 1);
  localparam int PW   = $clog2(DN);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;

  logic [CW-1:0]   key_r [DN];
  logic [DW-1:0]   dat_r [DN];
  logic [CNTW-1:0] cnt_r;
  logic [PW-1:0]   rd_ptr_r;

  logic            in_ready_r;
  logic            out_valid_r;
  logic [CW-1:0]   out_key_r;
  logic [DW-1:0]   out_dat_r;
  logic [PW-1:0]   out_idx_r;
  logic            out_last_r;

  logic            acc_s;
  logic            close_s;
  logic            drain_hs_s;
  logic            drain_end_s;
  logic [CNTW-1:0] cnt_inc_s;
  logic [CNTW-1:0] pos_s;
  logic [PW-1:0]   rd_ptr_inc_s;
  logic [DN-1:0]   prec_s;
  logic [CW-1:0]   key_ins_s [DN];
  logic [DW-1:0]   dat_ins_s [DN];

  // Handshake flags come from registers; rst_n only forces them low during reset.
  assign bus.in_ready  = in_ready_r & rst_n;
  assign bus.out_valid = out_valid_r & rst_n;
  assign bus.out_key   = out_key_r;
  assign bus.out_dat   = out_dat_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_last  = out_last_r;

  assign acc_s        = bus.in_valid & in_ready_r;
  assign cnt_inc_s    = cnt_r + CNTW'(1);
  assign close_s      = acc_s & (bus.in_last | (cnt_inc_s == CNTW'(DN)));
  assign drain_hs_s   = out_valid_r & bus.out_ready;
  assign drain_end_s  = drain_hs_s & out_last_r;
  assign rd_ptr_inc_s = rd_ptr_r + PW'(1);

  // Count valid entries that rank ahead of the incoming key; ties stay ahead (stable).
  always_comb begin
    prec_s = '0;
    pos_s  = '0;
    for (int i = 0; i < DN; i++) begin
      if (CNTW'(i) < cnt_r) begin
        if (MODE) begin
          prec_s[i] = (key_r[i] >= bus.in_key);
        end else begin
          prec_s[i] = (key_r[i] <= bus.in_key);
        end
      end else begin
        prec_s[i] = 1'b0;
      end
      pos_s = pos_s + CNTW'(prec_s[i]);
    end
  end

  // Post-insert array image: keep below pos, new pair at pos, shift the rest up one.
  always_comb begin
    key_ins_s[0] = (pos_s == CNTW'(0)) ? bus.in_key : key_r[0];
    dat_ins_s[0] = (pos_s == CNTW'(0)) ? bus.in_dat : dat_r[0];
    for (int i = 1; i < DN; i++) begin
      if (CNTW'(i) < pos_s) begin
        key_ins_s[i] = key_r[i];
        dat_ins_s[i] = dat_r[i];
      end else if (CNTW'(i) == pos_s) begin
        key_ins_s[i] = bus.in_key;
        dat_ins_s[i] = bus.in_dat;
      end else begin
        key_ins_s[i] = key_r[i-1];
        dat_ins_s[i] = dat_r[i-1];
      end
    end
  end

  // Next-state decode for the fill/drain phases.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (close_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = FILL;
        end
      end
      DRAIN: begin
        if (drain_end_s) begin
          state_next_s = FILL;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sorted storage; only written by an accepted beat, frozen while draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DN; i++) begin
        key_r[i] <= '0;
        dat_r[i] <= '0;
      end
    end else if (acc_s) begin
      for (int i = 0; i < DN; i++) begin
        key_r[i] <= key_ins_s[i];
        dat_r[i] <= dat_ins_s[i];
      end
    end
  end

  // Counters and output registers; rank 0 is preloaded from the insert image at close
  // so the first entry is presented the cycle after the closing beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      rd_ptr_r    <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_key_r   <= '0;
      out_dat_r   <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == FILL);
      out_valid_r <= (state_next_s == DRAIN);
      if (close_s) begin
        cnt_r      <= cnt_inc_s;
        rd_ptr_r   <= '0;
        out_key_r  <= key_ins_s[0];
        out_dat_r  <= dat_ins_s[0];
        out_idx_r  <= '0;
        out_last_r <= (cnt_inc_s == CNTW'(1));
      end else if (acc_s) begin
        cnt_r <= cnt_inc_s;
      end else if (drain_end_s) begin
        cnt_r      <= '0;
        rd_ptr_r   <= '0;
        out_key_r  <= '0;
        out_dat_r  <= '0;
        out_idx_r  <= '0;
        out_last_r <= 1'b0;
      end else if (drain_hs_s) begin
        rd_ptr_r   <= rd_ptr_inc_s;
        out_key_r  <= key_r[rd_ptr_inc_s];
        out_dat_r  <= dat_r[rd_ptr_inc_s];
        out_idx_r  <= rd_ptr_inc_s;
        out_last_r <= ((CNTW'(rd_ptr_inc_s) + CNTW'(1)) == cnt_r);
      end
    end
  end
endmodule

// File: tb/tb_stl_stream_sort.sv
// Bench for stl_stream_sort: ascending and descending instances, table vectors plus
// auto-close, backpressure, single-entry and reset-mid-drain sequences.
module tb_stl_stream_sort;
  localparam int DN = 16;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int IW = $clog2(DN);

  typedef struct packed {
    logic [CW-1:0] key;
    logic [DW-1:0] dat;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic               mode;
    logic [3:0]         n;
    logic [0:7][CW-1:0] key;
    logic [0:7][DW-1:0] dat;
    logic [0:7][CW-1:0] ek;
    logic [0:7][DW-1:0] ed;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stl_stream_sort_if #(.DN(DN), .CW(CW), .DW(DW)) bus_a ();
  stl_stream_sort_if #(.DN(DN), .CW(CW), .DW(DW)) bus_d ();

  stl_stream_sort #(.DN(DN), .CW(CW), .DW(DW), .MODE(1'b0)) u_asc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  stl_stream_sort #(.DN(DN), .CW(CW), .DW(DW), .MODE(1'b1)) u_dsc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_d)
  );

  int            total = 0;
  int            bad   = 0;
  beat_t         exp_a[$];
  beat_t         exp_d[$];
  vec_t          tv[7];
  logic [CW-1:0] bk[32];
  logic [DW-1:0] bd[32];
  beat_t         b;
  logic          ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input bit d, input beat_t e);
    if (d) exp_d.push_back(e);
    else   exp_a.push_back(e);
  endtask

  // Pop the scoreboard head for one accepted output beat and compare every field.
  task automatic take(input bit d, input beat_t got);
    beat_t e;
    if ((d ? exp_d.size() : exp_a.size()) == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_beat: got 0x%0h, want no beat at %0t", got, $time);
    end else begin
      if (d) e = exp_d.pop_front();
      else   e = exp_a.pop_front();
      chk("out_key",  64'(got.key),  64'(e.key));
      chk("out_dat",  64'(got.dat),  64'(e.dat));
      chk("out_idx",  64'(got.idx),  64'(e.idx));
      chk("out_last", 64'(got.last), 64'(e.last));
    end
  endtask

  beat_t cur_a, cur_d, prev_a, prev_d;
  logic  stall_a = 1'b0;
  logic  stall_d = 1'b0;
  assign cur_a = {bus_a.out_key, bus_a.out_dat, bus_a.out_idx, bus_a.out_last};
  assign cur_d = {bus_d.out_key, bus_d.out_dat, bus_d.out_idx, bus_d.out_last};

  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid) begin
      if (stall_a) chk("hold_a", 64'(cur_a), 64'(prev_a));
      if (bus_a.out_ready) take(1'b0, cur_a);
      stall_a <= ~bus_a.out_ready;
      prev_a  <= cur_a;
    end else begin
      stall_a <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_d.out_valid) begin
      if (stall_d) chk("hold_d", 64'(cur_d), 64'(prev_d));
      if (bus_d.out_ready) take(1'b1, cur_d);
      stall_d <= ~bus_d.out_ready;
      prev_d  <= cur_d;
    end else begin
      stall_d <= 1'b0;
    end
  end

  task automatic set_in(input bit d, input logic v, input logic [CW-1:0] k,
                        input logic [DW-1:0] dt, input logic l);
    if (d) begin
      bus_d.in_valid = v; bus_d.in_key = k; bus_d.in_dat = dt; bus_d.in_last = l;
    end else begin
      bus_a.in_valid = v; bus_a.in_key = k; bus_a.in_dat = dt; bus_a.in_last = l;
    end
  endtask

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input bit d, input logic [CW-1:0] k, input logic [DW-1:0] dt,
                      input logic l);
    logic done;
    done = 1'b0;
    set_in(d, 1'b1, k, dt, l);
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = d ? bus_d.in_ready : bus_a.in_ready;
      @(posedge clk);
      #1;
    end
    set_in(d, 1'b0, '0, '0, 1'b0);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0, want 1 at %0t", $time);
    end
  endtask

  task automatic wait_drain(input bit d);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(posedge clk);
      #1;
      if (d) done = (exp_d.size() == 0) && !bus_d.out_valid;
      else   done = (exp_a.size() == 0) && !bus_a.out_valid;
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  // Reference stable sort: repeatedly take the best unused key, earliest arrival on ties.
  task automatic push_ref(input bit d, input int n, input bit mode);
    bit    used[32];
    int    best;
    beat_t e;
    for (int i = 0; i < 32; i++) used[i] = 1'b0;
    for (int r = 0; r < n; r++) begin
      best = -1;
      for (int i = 0; i < n; i++) begin
        if (!used[i]) begin
          if (best < 0) best = i;
          else if (mode ? (bk[i] > bk[best]) : (bk[i] < bk[best])) best = i;
        end
      end
      used[best] = 1'b1;
      e.key  = bk[best];
      e.dat  = bd[best];
      e.idx  = IW'(r);
      e.last = (r == n - 1);
      push(d, e);
    end
  endtask

  task automatic run_batch(input bit d, input int n);
    for (int i = 0; i < n; i++) send(d, bk[i], bd[i], (i == n - 1));
  endtask

  initial begin
    tv[0] = '{mode: 1'b0, n: 4'd4,
              key: {8'd9, 8'd3, 8'd7, 8'd3, 32'd0},
              dat: {16'd0, 16'd1, 16'd2, 16'd3, 64'd0},
              ek:  {8'd3, 8'd3, 8'd7, 8'd9, 32'd0},
              ed:  {16'd1, 16'd3, 16'd2, 16'd0, 64'd0}};
    tv[1] = '{mode: 1'b1, n: 4'd4,
              key: {8'd5, 8'd200, 8'd5, 8'd0, 32'd0},
              dat: {16'd0, 16'd1, 16'd2, 16'd3, 64'd0},
              ek:  {8'd200, 8'd5, 8'd5, 8'd0, 32'd0},
              ed:  {16'd1, 16'd0, 16'd2, 16'd3, 64'd0}};
    tv[2] = '{mode: 1'b0, n: 4'd1,
              key: {8'd42, 56'd0},
              dat: {16'hbeef, 112'd0},
              ek:  {8'd42, 56'd0},
              ed:  {16'hbeef, 112'd0}};
    tv[3] = '{mode: 1'b0, n: 4'd2,
              key: {8'd255, 8'd0, 48'd0},
              dat: {16'd1, 16'd2, 96'd0},
              ek:  {8'd0, 8'd255, 48'd0},
              ed:  {16'd2, 16'd1, 96'd0}};
    tv[4] = '{mode: 1'b1, n: 4'd3,
              key: {8'd7, 8'd7, 8'd7, 40'd0},
              dat: {16'd10, 16'd11, 16'd12, 80'd0},
              ek:  {8'd7, 8'd7, 8'd7, 40'd0},
              ed:  {16'd10, 16'd11, 16'd12, 80'd0}};
    tv[5] = '{mode: 1'b1, n: 4'd5,
              key: {8'd1, 8'd255, 8'd0, 8'd128, 8'd255, 24'd0},
              dat: {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 48'd0},
              ek:  {8'd255, 8'd255, 8'd128, 8'd1, 8'd0, 24'd0},
              ed:  {16'd1, 16'd4, 16'd3, 16'd0, 16'd2, 48'd0}};
    tv[6] = '{mode: 1'b0, n: 4'd8,
              key: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
              dat: {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7},
              ek:  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
              ed:  {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}};

    set_in(1'b0, 1'b0, '0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0);
    bus_a.out_ready = 1'b1;
    bus_d.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_out_key",   64'(bus_a.out_key),   64'd0);
    chk("rst_out_dat",   64'(bus_a.out_dat),   64'd0);
    chk("rst_out_idx",   64'(bus_a.out_idx),   64'd0);
    chk("rst_out_last",  64'(bus_a.out_last),  64'd0);
    chk("rst_out_valid_d", 64'(bus_d.out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready",   64'(bus_a.in_ready), 64'd1);
    chk("release_in_ready_d", 64'(bus_d.in_ready), 64'd1);

    // Table vectors
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < int'(tv[v].n); i++) begin
        b.key  = tv[v].ek[i];
        b.dat  = tv[v].ed[i];
        b.idx  = IW'(i);
        b.last = (i == int'(tv[v].n) - 1);
        push(tv[v].mode, b);
      end
      for (int i = 0; i < int'(tv[v].n); i++)
        send(tv[v].mode, tv[v].key[i], tv[v].dat[i], (i == int'(tv[v].n) - 1));
      if (tv[v].mode) begin
        chk("latency_valid",    64'(bus_d.out_valid), 64'd1);
        chk("latency_in_ready", 64'(bus_d.in_ready),  64'd0);
      end else begin
        chk("latency_valid",    64'(bus_a.out_valid), 64'd1);
        chk("latency_in_ready", 64'(bus_a.in_ready),  64'd0);
      end
      wait_drain(tv[v].mode);
    end

    // Single entry, then a back-to-back batch
    b = {8'd77, 16'd5, IW'(0), 1'b1};
    push(1'b0, b);
    send(1'b0, 8'd77, 16'd5, 1'b1);
    @(negedge clk);
    chk("single_in_ready_low", 64'(bus_a.in_ready), 64'd0);
    chk("single_last",         64'(bus_a.out_last), 64'd1);
    @(posedge clk);
    #1;
    chk("single_in_ready_back", 64'(bus_a.in_ready),  64'd1);
    chk("single_valid_drop",    64'(bus_a.out_valid), 64'd0);
    bk[0] = 8'd3; bd[0] = 16'd100;
    bk[1] = 8'd1; bd[1] = 16'd101;
    push_ref(1'b0, 2, 1'b0);
    run_batch(1'b0, 2);
    wait_drain(1'b0);

    // Auto-close at DN entries, in_last never set
    for (int i = 0; i < DN; i++) begin
      bk[i] = CW'(15 - i);
      bd[i] = DW'(i);
    end
    push_ref(1'b0, DN, 1'b0);
    for (int i = 0; i < DN; i++) send(1'b0, bk[i], bd[i], 1'b0);
    chk("autoclose_in_ready", 64'(bus_a.in_ready),  64'd0);
    chk("autoclose_valid",    64'(bus_a.out_valid), 64'd1);
    wait_drain(1'b0);
    bk[0] = 8'd50; bk[1] = 8'd40; bk[2] = 8'd60; bk[3] = 8'd45; bk[4] = 8'd44;
    for (int i = 0; i < 5; i++) bd[i] = DW'(200 + i);
    push_ref(1'b0, 5, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, bk[i], bd[i], 1'b0);
    chk("next_batch_open",     64'(bus_a.in_ready),  64'd1);
    chk("next_batch_no_valid", 64'(bus_a.out_valid), 64'd0);
    send(1'b0, bk[4], bd[4], 1'b1);
    wait_drain(1'b0);

    // Backpressure with out_ready pattern 1,0,0
    for (int i = 0; i < 8; i++) begin
      bk[i] = CW'($urandom_range(0, 5));
      bd[i] = DW'($urandom);
    end
    push_ref(1'b0, 8, 1'b0);
    bus_a.out_ready = 1'b0;
    run_batch(1'b0, 8);
    for (int t = 0; t < 200 && exp_a.size() != 0; t++) begin
      bus_a.out_ready = (t % 3 == 0);
      @(posedge clk);
      #1;
    end
    bus_a.out_ready = 1'b1;
    wait_drain(1'b0);

    // Reset after two of six entries are drained
    bk[0] = 8'd30; bk[1] = 8'd10; bk[2] = 8'd20; bk[3] = 8'd50; bk[4] = 8'd40; bk[5] = 8'd0;
    for (int i = 0; i < 6; i++) bd[i] = DW'(300 + i);
    push_ref(1'b0, 6, 1'b0);
    run_batch(1'b0, 6);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clk);
      #1;
      ok = (exp_a.size() == 4);
    end
    chk("two_drained", 64'(ok), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid_low", 64'(bus_a.out_valid), 64'd0);
    chk("midrst_ready_low", 64'(bus_a.in_ready),  64'd0);
    exp_a.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_valid_after", 64'(bus_a.out_valid), 64'd0);
    chk("midrst_idx",         64'(bus_a.out_idx),   64'd0);
    chk("midrst_last",        64'(bus_a.out_last),  64'd0);
    chk("midrst_key",         64'(bus_a.out_key),   64'd0);
    @(posedge clk);
    #1;
    chk("midrst_ready_back", 64'(bus_a.in_ready),  64'd1);
    chk("midrst_no_valid",   64'(bus_a.out_valid), 64'd0);
    bk[0] = 8'd9; bk[1] = 8'd1; bk[2] = 8'd5;
    for (int i = 0; i < 3; i++) bd[i] = DW'(400 + i);
    push_ref(1'b0, 3, 1'b0);
    run_batch(1'b0, 3);
    wait_drain(1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_a_empty", 64'(exp_a.size()), 64'd0);
    chk("queue_d_empty", 64'(exp_d.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
